// File: rtl/surf_event_merger.sv
// Merges per-SURF byte streams into one framed event: header, tagged per-SURF sections, trailer.
// A silent SURF is abandoned after TIMEOUT idle cycles so one dead board cannot stall readout.
module surf_event_merger #(
    parameter logic [15:0] TIMEOUT   = 16'd1024,
    parameter logic [3:0]  HDR_MAGIC = 4'hA
) (
    input  logic        sysclk_i,
    input  logic        rst_i,
    input  logic [6:0]  surf_mask_i,
    input  logic [55:0] s_dout_tdata,
    input  logic [6:0]  s_dout_tvalid,
    output logic [6:0]  s_dout_tready,
    input  logic [6:0]  s_dout_tlast,
    output logic [7:0]  m_ev_tdata,
    output logic        m_ev_tvalid,
    input  logic        m_ev_tready,
    output logic        m_ev_tlast,
    output logic [11:0] event_count_o,
    output logic        timeout_err_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_TAG, S_DATA, S_TRAILER
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [6:0]  r_mask;
    logic [6:0]  r_abandon;
    logic [2:0]  r_cur;
    logic [15:0] r_to_cnt;
    logic [11:0] r_count;
    logic        r_err;

    logic [7:0]  w_lane [7];
    logic [6:0]  w_above;
    logic [2:0]  w_first_idx;
    logic        w_first_vld;
    logic [2:0]  w_next_idx;
    logic        w_next_vld;
    logic        w_start;
    logic        w_cur_valid;
    logic        w_cur_last;
    logic        w_timeout;
    logic        w_sec_end;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_lane
            assign w_lane[gi] = s_dout_tdata[8*gi +: 8];
        end
    endgenerate

    // Unmasked SURFs with a strictly higher index than the one being read.
    assign w_above     = ~r_mask & (7'h7E << r_cur);
    assign w_start     = |(s_dout_tvalid & ~surf_mask_i);
    assign w_cur_valid = s_dout_tvalid[r_cur];
    assign w_cur_last  = s_dout_tlast[r_cur];
    assign w_timeout   = (r_state == S_DATA) && !w_cur_valid && (r_to_cnt == TIMEOUT - 16'd1);
    assign w_sec_end   = (r_state == S_DATA) && ((w_cur_valid && m_ev_tready && w_cur_last) || w_timeout);

    always_comb begin
        w_first_idx = 3'd0;
        w_first_vld = 1'b0;
        w_next_idx  = 3'd0;
        w_next_vld  = 1'b0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = 6; i >= 0; i--) begin
            if (!r_mask[i]) begin
                w_first_idx = 3'(i);
                w_first_vld = 1'b1;
            end
            if (w_above[i]) begin
                w_next_idx = 3'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        m_ev_tvalid   = 1'b0;
        m_ev_tdata    = 8'h00;
        m_ev_tlast    = 1'b0;
        s_dout_tready = 7'h00;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = S_HDR0;
            end
            S_HDR0: begin
                m_ev_tvalid = 1'b1;
                m_ev_tdata  = {HDR_MAGIC, r_count[11:8]};
                if (m_ev_tready) w_state_next = S_HDR1;
            end
            S_HDR1: begin
                m_ev_tvalid = 1'b1;
                m_ev_tdata  = r_count[7:0];
                if (m_ev_tready) w_state_next = S_HDR2;
            end
            S_HDR2: begin
                m_ev_tvalid = 1'b1;
                m_ev_tdata  = {1'b0, ~r_mask};
                if (m_ev_tready) w_state_next = w_first_vld ? S_TAG : S_TRAILER;
            end
            S_TAG: begin
                m_ev_tvalid = 1'b1;
                m_ev_tdata  = {5'b11000, r_cur};
                if (m_ev_tready) w_state_next = S_DATA;
            end
            S_DATA: begin
                m_ev_tvalid          = w_cur_valid;
                m_ev_tdata           = w_lane[r_cur];
                s_dout_tready[r_cur] = m_ev_tready;
                if (w_sec_end) w_state_next = w_next_vld ? S_TAG : S_TRAILER;
            end
            S_TRAILER: begin
                m_ev_tvalid = 1'b1;
                m_ev_tdata  = {1'b1, r_abandon};
                m_ev_tlast  = 1'b1;
                if (m_ev_tready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mask    <= 7'h7F;
            r_abandon <= 7'h00;
            r_cur     <= 3'd0;
            r_to_cnt  <= 16'd0;
            r_count   <= 12'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) r_mask <= surf_mask_i;
                end
                S_HDR2: begin
                    if (m_ev_tready) r_cur <= w_first_idx;
                end
                S_TAG: begin
                    if (m_ev_tready) r_to_cnt <= 16'd0;
                end
                S_DATA: begin
                    // A downstream stall with data pending does not count toward the timeout.
                    if (w_cur_valid) begin
                        if (m_ev_tready) r_to_cnt <= 16'd0;
                    end else if (w_timeout) begin
                        r_abandon[r_cur] <= 1'b1;
                        r_err            <= 1'b1;
                        r_to_cnt         <= 16'd0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                    if (w_sec_end && w_next_vld) r_cur <= w_next_idx;
                end
                S_TRAILER: begin
                    if (m_ev_tready) begin
                        r_count   <= r_count + 12'd1;
                        r_abandon <= 7'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign event_count_o = r_count;
    assign timeout_err_o = r_err;
    assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_surf_event_merger.sv
// Bench for surf_event_merger: directed vector table, reset/mask corner sequences, random events
// checked against a byte-stream model, and a full event-counter wrap.
module tb_surf_event_merger;

    localparam logic [15:0] TO = 16'd16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [6:0]  surf_mask_i;
    logic [55:0] s_dout_tdata;
    logic [6:0]  s_dout_tvalid;
    logic [6:0]  s_dout_tready;
    logic [6:0]  s_dout_tlast;
    logic [7:0]  m_ev_tdata;
    logic        m_ev_tvalid;
    logic        m_ev_tready;
    logic        m_ev_tlast;
    logic [11:0] event_count_o;
    logic        timeout_err_o;
    logic        busy_o;

    always #5 clk = ~clk;

    surf_event_merger #(.TIMEOUT(TO), .HDR_MAGIC(4'hA)) dut (
        .sysclk_i(clk), .rst_i(rst_i), .surf_mask_i(surf_mask_i),
        .s_dout_tdata(s_dout_tdata), .s_dout_tvalid(s_dout_tvalid), .s_dout_tready(s_dout_tready),
        .s_dout_tlast(s_dout_tlast), .m_ev_tdata(m_ev_tdata), .m_ev_tvalid(m_ev_tvalid),
        .m_ev_tready(m_ev_tready), .m_ev_tlast(m_ev_tlast), .event_count_o(event_count_o),
        .timeout_err_o(timeout_err_o), .busy_o(busy_o)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [6:0] mask;
        logic [6:0] silent;
        int         nbytes;
        int         mode;
        bit         gaps;
        logic [7:0] exp_hdr2;
        logic [7:0] exp_trl;
        int         exp_len;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    bq_t        frames [7];
    bq_t        src_q  [7];
    logic [6:0] src_vld;
    int         idle_run [7];
    int         tmode;
    bit         gaps_en;
    bit         scramble;
    logic [8:0] out_q[$];
    int         out_cyc[$];
    logic [8:0] exp_q[$];
    int         ab_pos[$];
    logic [6:0] exp_ab;
    int         cyc = 0;
    bit         trl_seen;
    bit         stall_prev = 0;
    logic [8:0] prev_word;
    logic [11:0] m_count = 12'd0;
    bit          m_err = 0;
    vec_t        vt [6];
    logic [8:0]  exp38 [8] = '{9'h0A0, 9'h000, 9'h001, 9'h0C0, 9'h011, 9'h022, 9'h033, 9'h180};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic check_reset(input string nm);
        check({nm, " tvalid"}, m_ev_tvalid, 0);
        check({nm, " tlast"}, m_ev_tlast, 0);
        check({nm, " tdata"}, m_ev_tdata, 0);
        check({nm, " s_tready"}, s_dout_tready, 0);
        check({nm, " count"}, event_count_o, 0);
        check({nm, " err"}, timeout_err_o, 0);
        check({nm, " busy"}, busy_o, 0);
    endtask

    // Expected event as a list of {tlast, byte}, straight from the framing rules.
    function automatic void build_exp(input logic [11:0] cnt, input logic [6:0] mask);
        exp_q.delete();
        ab_pos.delete();
        exp_ab = 7'h00;
        exp_q.push_back({1'b0, 4'hA, cnt[11:8]});
        exp_q.push_back({1'b0, cnt[7:0]});
        exp_q.push_back({1'b0, 1'b0, ~mask});
        for (int n = 0; n < 7; n++) begin
            if (!mask[n]) begin
                exp_q.push_back({1'b0, 8'hC0 + 8'(n)});
                if (frames[n].size() == 0) begin
                    exp_ab[n] = 1'b1;
                    ab_pos.push_back(exp_q.size() - 1);
                end else begin
                    foreach (frames[n][k]) exp_q.push_back({1'b0, frames[n][k]});
                end
            end
        end
        exp_q.push_back({1'b1, 1'b1, exp_ab});
    endfunction

    task automatic set_frames(input logic [6:0] silent, input int nbytes, input bit rnd);
        for (int n = 0; n < 7; n++) begin
            frames[n].delete();
            if (!silent[n]) begin
                int c;
                c = rnd ? int'($urandom_range(4, 1)) : nbytes;
                for (int k = 0; k < c; k++)
                    frames[n].push_back(rnd ? 8'($urandom) : 8'((k + 1) * 17 + n * 64));
            end
        end
    endtask

    task automatic clear_sources();
        for (int n = 0; n < 7; n++) begin
            src_q[n].delete();
            idle_run[n] = 0;
        end
        src_vld       = 7'h00;
        s_dout_tvalid = 7'h00;
        s_dout_tlast  = 7'h00;
        s_dout_tdata  = '0;
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later, before the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int n = 0; n < 7; n++) begin
            if (!src_vld[n] && src_q[n].size() > 0) begin
                if (!gaps_en || idle_run[n] >= 3 || $urandom_range(3, 0) != 0) begin
                    src_vld[n]  = 1'b1;
                    idle_run[n] = 0;
                end else begin
                    idle_run[n]++;
                end
            end
            s_dout_tvalid[n]       = src_vld[n];
            s_dout_tdata[8*n +: 8] = src_vld[n] ? src_q[n][0] : 8'h00;
            s_dout_tlast[n]        = src_vld[n] && (src_q[n].size() == 1);
        end
        case (tmode)
            0:       m_ev_tready = 1'b1;
            1:       m_ev_tready = cyc[0];
            default: m_ev_tready = ($urandom_range(9, 0) < 7);
        endcase
        if (scramble && busy_o) surf_mask_i = 7'($urandom);
        #1;
        check("tready_onehot", s_dout_tready & (s_dout_tready - 7'd1), 0);
        if (stall_prev) begin
            check("stall_valid", m_ev_tvalid, 1);
            check("stall_word", {m_ev_tlast, m_ev_tdata}, prev_word);
        end
        stall_prev = m_ev_tvalid && !m_ev_tready;
        prev_word  = {m_ev_tlast, m_ev_tdata};
        for (int n = 0; n < 7; n++) begin
            if (src_vld[n] && s_dout_tready[n]) begin
                void'(src_q[n].pop_front());
                src_vld[n] = 1'b0;
            end
        end
        if (m_ev_tvalid && m_ev_tready) begin
            out_q.push_back({m_ev_tlast, m_ev_tdata});
            out_cyc.push_back(cyc);
            if (m_ev_tlast) trl_seen = 1;
        end
    endtask

    task automatic run_event(input logic [6:0] mask, input int mode, input bit gaps, input bit scr,
                             input bit quiet, input string nm);
        int budget;
        build_exp(m_count, mask);
        clear_sources();
        for (int n = 0; n < 7; n++) src_q[n] = frames[n];
        surf_mask_i = mask;
        tmode       = mode;
        gaps_en     = gaps;
        scramble    = scr;
        out_q.delete();
        out_cyc.delete();
        trl_seen = 0;
        budget   = 0;
        while (!trl_seen && budget < 3000) begin
            step();
            budget++;
        end
        check({nm, " done"}, trl_seen, 1);
        check({nm, " len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s byte%0d", nm, i), out_q[i], exp_q[i]);
        if (mode == 0) begin
            foreach (ab_pos[j]) begin
                if (ab_pos[j] + 1 < out_cyc.size())
                    check({nm, " timeout_gap"}, out_cyc[ab_pos[j] + 1] - out_cyc[ab_pos[j]], 32'(TO) + 1);
            end
        end
        for (int n = 0; n < 7; n++)
            if (mask[n]) check({nm, " masked_untouched"}, src_q[n].size(), frames[n].size());
        m_count = m_count + 12'd1;
        if (exp_ab != 7'h00) m_err = 1;
        @(negedge clk);
        clear_sources();
        scramble    = 0;
        surf_mask_i = 7'h7F;
        #1;
        check({nm, " idle_busy"}, busy_o, 0);
        check({nm, " count"}, event_count_o, m_count);
        check({nm, " err"}, timeout_err_o, m_err);
        if (!quiet)
            $display("event %s: mask=%02h bytes=%0d trailer=%03h count=%0d err=%0d", nm, mask,
                     out_q.size(), (out_q.size() > 0) ? out_q[$] : 9'h0, event_count_o, timeout_err_o);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        surf_mask_i = 7'h7F;
        m_ev_tready = 1'b0;
        tmode = 0; gaps_en = 0; scramble = 0;
        clear_sources();

        vt[0] = '{7'h7E, 7'h00, 3, 0, 0, 8'h01, 8'h80, 8};
        vt[1] = '{7'h00, 7'h00, 2, 1, 1, 8'h7F, 8'h80, 25};
        vt[2] = '{7'h7C, 7'h02, 1, 0, 0, 8'h03, 8'h82, 7};
        vt[3] = '{7'h7B, 7'h00, 1, 0, 1, 8'h04, 8'h80, 6};
        vt[4] = '{7'h2A, 7'h00, 2, 1, 1, 8'h55, 8'h80, 16};
        vt[5] = '{7'h00, 7'h41, 1, 2, 1, 8'h7F, 8'hC1, 16};

        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_i = 1'b0;

        for (int v = 0; v < 6; v++) begin
            set_frames(vt[v].silent, vt[v].nbytes, 0);
            run_event(vt[v].mask, vt[v].mode, vt[v].gaps, 0, 0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d tbl_len", v), out_q.size(), vt[v].exp_len);
            if (out_q.size() >= 3) begin
                check($sformatf("vec%0d tbl_hdr2", v), out_q[2], {1'b0, vt[v].exp_hdr2});
                check($sformatf("vec%0d tbl_trl", v), out_q[$], {1'b1, vt[v].exp_trl});
            end
            if (v == 0)
                for (int i = 0; i < 8 && i < out_q.size(); i++)
                    check($sformatf("first_event byte%0d", i), out_q[i], exp38[i]);
            if (v == 3) check("err_sticky", timeout_err_o, 1);
        end

        // All SURFs masked while all present data: nothing may happen.
        surf_mask_i   = 7'h7F;
        s_dout_tvalid = 7'h7F;
        s_dout_tdata  = {$urandom, $urandom};
        m_ev_tready   = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            check("all_masked", {busy_o, s_dout_tready, m_ev_tvalid}, 0);
        end
        $display("all-masked hold: 100 cycles observed");
        @(negedge clk);
        clear_sources();

        // Reset in the middle of SURF3's data section.
        begin
            bit seen;
            int budget;
            set_frames(7'h00, 4, 0);
            for (int n = 0; n < 7; n++) src_q[n] = frames[n];
            surf_mask_i = 7'h00; tmode = 0; gaps_en = 0;
            out_q.delete(); out_cyc.delete(); trl_seen = 0;
            seen = 0; budget = 0;
            while (!seen && budget < 500) begin
                step();
                budget++;
                if (out_q.size() > 0 && out_q[$] == 9'h0C3) seen = 1;
            end
            check("reset_reach_surf3", seen, 1);
            step();
            step();
            check("reset_in_data busy", busy_o, 1);
            @(negedge clk);
            rst_i = 1'b1;
            clear_sources();
            stall_prev = 0;
            @(negedge clk);
            #1;
            check_reset("midreset");
            check("midreset no_trailer", trl_seen, 0);
            $display("mid-event reset: partial event of %0d bytes discarded", out_q.size());
            @(negedge clk);
            rst_i   = 1'b0;
            m_count = 12'd0;
            m_err   = 0;
        end
        set_frames(7'h00, 1, 0);
        run_event(7'h55, 0, 0, 0, 0, "post_reset");
        check("post_reset hdr0", out_q[0], 9'h0A0);
        check("post_reset hdr1", out_q[1], 9'h000);

        for (int e = 0; e < 30; e++) begin
            logic [6:0] m;
            logic [6:0] sil;
            do begin
                m = 7'($urandom);
                for (int n = 0; n < 7; n++) sil[n] = ($urandom_range(7, 0) == 0);
            end while ((~m & ~sil) == 7'h00);
            set_frames(sil, 0, 1);
            run_event(m, 2, 1, 1, 0, $sformatf("rnd%0d", e));
        end

        set_frames(7'h7E, 1, 0);
        while (m_count != 12'hFFF) run_event(7'h7E, 0, 0, 0, 1, "fill");
        run_event(7'h7E, 0, 0, 0, 0, "wrap");
        check("wrap hdr0", out_q[0], 9'h0AF);
        check("wrap hdr1", out_q[1], 9'h0FF);
        check("wrap count", event_count_o, 0);
        run_event(7'h7E, 0, 0, 0, 0, "after_wrap");
        check("after_wrap hdr0", out_q[0], 9'h0A0);
        check("after_wrap hdr1", out_q[1], 9'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
